des_key_schedule: RTL and testbench

Sequential DES key-schedule engine that accepts a 64-bit key and streams the sixteen 48-bit round keys to the round datapath, one per handshake. It sits directly upstream of the Feistel round logic. It applies PC-1 once at load, then performs the per-round 28-bit half rotations in a single iterated register instead of sixteen unrolled stages. Encrypt order (K1..K16) and decrypt order (K16..K1) are both supported.

---
 rtl/des_pkg.sv | 39 +++
 rtl/p_box_56_48.sv | 18 +
 rtl/p_box_64_56.sv | 18 +
 rtl/des_key_schedule.sv | 96 +++++++++
 tb/tb_des_key_schedule.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared types, tables and rotation helpers for the DES key-schedule engine.
package des_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Left-rotate amount per DES round index 0..15.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Tables use FIPS 46 bit numbers (1 = MSB of the source word).
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Schedule amounts are only ever 1 or 2.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/p_box_56_48.sv
// PC-2: compresses the 56-bit C/D register into a 48-bit round key.
module p_box_56_48
  import des_pkg::*;
(
  input  logic [55:0] in_i,
  output logic [47:0] out_o
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign out_o[47-i] = in_i[56-PC2_TBL[i]];
  end

  // C/D bits 9,18,22,25,35,38,43,54 are not part of any round key.
  logic unused_cd;
  assign unused_cd = ^{in_i[47], in_i[38], in_i[34], in_i[31],
                       in_i[21], in_i[18], in_i[13], in_i[2]};

endmodule

// File: rtl/p_box_64_56.sv
// PC-1: selects the 56 key bits from a 64-bit DES key, dropping parity.
module p_box_64_56
  import des_pkg::*;
(
  input  logic [63:0] in_i,
  output logic [55:0] out_o
);

  for (genvar i = 0; i < 56; i++) begin : g_bit
    assign out_o[55-i] = in_i[64-PC1_TBL[i]];
  end

  // DES bits 8,16,..,64 are parity and never routed.
  logic unused_parity;
  assign unused_parity = ^{in_i[56], in_i[48], in_i[40], in_i[32],
                           in_i[24], in_i[16], in_i[8],  in_i[0]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterated DES key schedule: one C/D register rotated per handshake, 16 round
// keys streamed in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk_out,
  output logic [3:0]  rk_idx,
  output logic        rk_last,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  idx_q, idx_d;
  logic        dir_q, dir_d;
  logic [55:0] pc1_key;
  logic        accept, fire;

  p_box_64_56 u_pc1 (.in_i(key_in), .out_o(pc1_key));
  p_box_56_48 u_pc2 (.in_i(cd_q),   .out_o(rk_out));

  assign accept = key_valid && key_ready;
  assign fire   = rk_valid && rk_ready;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (fire && idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unshifted PC-1 is C16D16, the starting point for decrypt order.
  always_comb begin
    cd_d  = cd_q;
    idx_d = idx_q;
    dir_d = dir_q;
    if (accept) begin
      dir_d = decrypt;
      idx_d = '0;
      cd_d  = decrypt ? pc1_key
                      : {rotl28(pc1_key[55:28], SHIFT_SCHED[0]),
                         rotl28(pc1_key[27:0],  SHIFT_SCHED[0])};
    end else if (fire) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 4'd1;
        cd_d  = dir_q ? {rotr28(cd_q[55:28], SHIFT_SCHED[4'd15 - idx_q]),
                         rotr28(cd_q[27:0],  SHIFT_SCHED[4'd15 - idx_q])}
                      : {rotl28(cd_q[55:28], SHIFT_SCHED[idx_q + 4'd1]),
                         rotl28(cd_q[27:0],  SHIFT_SCHED[idx_q + 4'd1])};
      end
    end
  end

  always_comb begin
    key_ready = (state_q == IDLE);
    rk_valid  = (state_q == RUN);
    busy      = (state_q == RUN);
    rk_last   = (state_q == RUN) && (idx_q == LAST_IDX);
    rk_idx    = idx_q;
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: FIPS 46 key-schedule model feeding a scoreboard
// that is compared against the streamed round keys on every valid cycle.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_out;
  logic [3:0]  rk_idx;
  logic        rk_last;
  logic        busy;

  des_key_schedule dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .decrypt(decrypt),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference key schedule straight from FIPS 46.
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [47:0] ks [16];

  function automatic logic [55:0] m_pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-pc1_t[i]];
    return r;
  endfunction

  function automatic logic [47:0] m_pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-pc2_t[i]];
    return r;
  endfunction

  function automatic void build_ks(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    cd = m_pc1(k);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < sh_t[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[r] = m_pc2({c, d});
    end
  endfunction

  typedef struct {
    logic [47:0] k;
    logic [3:0]  idx;
  } exp_t;
  exp_t exp_q [$];
  bit   chk_en   = 1'b0;
  int   hs_count = 0;

  function automatic void push_expected(input logic [63:0] k, input bit dec);
    exp_t e;
    build_ks(k);
    for (int j = 0; j < 16; j++) begin
      e.idx = 4'(j);
      e.k   = dec ? ks[15-j] : ks[j];
      exp_q.push_back(e);
    end
  endfunction

  // Single compare process: every valid cycle is checked against the scoreboard head.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("key_ready_vs_run", {63'd0, key_ready}, {63'd0, !rk_valid});
      check("busy_vs_run", {63'd0, busy}, {63'd0, rk_valid});
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rk_valid", {63'd0, rk_valid}, 64'd0);
        end else begin
          check("rk_out", {16'd0, rk_out}, {16'd0, exp_q[0].k});
          check("rk_idx", {60'd0, rk_idx}, {60'd0, exp_q[0].idx});
          check("rk_last", {63'd0, rk_last}, {63'd0, exp_q[0].idx == 4'd15});
          if (rk_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [63:0] k, input bit dec, input bit hold);
    int n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("key_ready_timeout", 64'd0, 64'd1);
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    push_expected(k, dec);
    tick();
    if (!hold) begin
      key_valid = 1'b0;
      decrypt   = ~dec;
      key_in    = ~k;
    end
    @(negedge clk);
    check("first_key_latency", {63'd0, rk_valid}, 64'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
    check("idle_after_stream", {63'd0, rk_valid}, 64'd0);
  endtask

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;

  initial begin
    int hs0, n, run1, gap, phase;
    rst = 1'b1; key_valid = 1'b0; key_in = '0; decrypt = 1'b0; rk_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rk_valid", {63'd0, rk_valid}, 64'd0);
    check("rst_key_ready", {63'd0, key_ready}, 64'd1);
    check("rst_rk_idx", {60'd0, rk_idx}, 64'd0);
    check("rst_rk_last", {63'd0, rk_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rk_out", {16'd0, rk_out}, 64'd0);

    // Pin the model to FIPS 46 worked-example values.
    check("model_pc1", {8'd0, m_pc1(K1)}, 64'h00F0CCAAF556678F);
    build_ks(K1);
    check("model_k1", {16'd0, ks[0]}, 64'h1B02EFFC7072);
    check("model_k2", {16'd0, ks[1]}, 64'h79AED9DBC9E5);
    check("model_k16", {16'd0, ks[15]}, 64'hCB3D8B0E17F5);
    chk_en = 1'b1;

    // Encrypt stream, plus the C1D1 register content after load.
    load_key(K1, 1'b0, 1'b0);
    check("cd_after_load", {8'd0, dut.cd_q}, 64'h00E19955FAACCF1E);
    drain(40);

    // Decrypt stream: reverse order.
    load_key(K1, 1'b1, 1'b0);
    check("model_dec_first", {16'd0, ks[15]}, 64'hCB3D8B0E17F5);
    drain(40);

    // Pseudo-random backpressure.
    hs0 = hs_count;
    load_key(K1, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rk_ready = 1'b1;
    drain(40);
    check("bp_handshakes", 64'(hs_count - hs0), 64'd16);

    // key_valid held through RUN with a second key; exactly one idle cycle between streams.
    load_key(K1, 1'b0, 1'b1);
    key_in  = K2;
    decrypt = 1'b1;
    push_expected(K2, 1'b1);
    run1 = 1; gap = 0; phase = 0; n = 0;
    while (phase < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (phase == 0) begin
        if (rk_valid) run1++;
        else begin gap = 1; phase = 1; end
      end else begin
        if (rk_valid) begin key_valid = 1'b0; phase = 2; end
        else gap++;
      end
    end
    key_valid = 1'b0;
    check("hold_first_run_len", 64'(run1), 64'd16);
    check("hold_gap_len", 64'(gap), 64'd1);
    drain(40);

    // Synchronous reset mid-stream at rk_idx 7.
    load_key(K1, 1'b0, 1'b0);
    n = 0;
    while (rk_idx != 4'd7 && n < 40) begin
      tick();
      n++;
    end
    check("reached_idx7", {60'd0, rk_idx}, 64'd7);
    chk_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_rk_valid", {63'd0, rk_valid}, 64'd0);
    check("abort_key_ready", {63'd0, key_ready}, 64'd1);
    check("abort_rk_idx", {60'd0, rk_idx}, 64'd0);
    chk_en = 1'b1;
    load_key(K1, 1'b0, 1'b0);
    drain(40);

    // Degenerate keys: rotations cannot change an all-equal C/D.
    build_ks(64'd0);
    check("model_zero_k5", {16'd0, ks[4]}, 64'd0);
    load_key(64'd0, 1'b0, 1'b0);
    drain(40);
    build_ks('1);
    check("model_ones_k9", {16'd0, ks[8]}, 64'hFFFFFFFFFFFF);
    load_key('1, 1'b1, 1'b0);
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
